// File: rtl/writeback_arbiter_if.sv
// rtl/writeback_arbiter_if.sv - unit result inputs, stall returns and ARF/scoreboard outputs of the writeback arbiter
interface writeback_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  am_wb_valid;
    logic [ADDR_WIDTH-1:0] am_wb_regdest;
    logic                  am_wb_writereg;
    logic [DATA_WIDTH-1:0] am_wb_data;
    logic                  mem_wb_valid;
    logic [ADDR_WIDTH-1:0] mem_wb_regdest;
    logic                  mem_wb_writereg;
    logic [DATA_WIDTH-1:0] mem_wb_data;
    logic                  mul_wb_valid;
    logic [ADDR_WIDTH-1:0] mul_wb_regdest;
    logic                  mul_wb_writereg;
    logic [DATA_WIDTH-1:0] mul_wb_data;
    logic                  wb_am_stall;
    logic                  wb_mem_stall;
    logic                  wb_mul_stall;
    logic [ADDR_WIDTH-1:0] wb_reg_writeaddr;
    logic [DATA_WIDTH-1:0] wb_reg_writedata;
    logic                  wb_reg_enablewrite;
    logic                  wb_sb_clear;
    logic [ADDR_WIDTH-1:0] wb_sb_clearaddr;
    logic [1:0]            wb_sb_clearunit;

    modport slave (
        input  am_wb_valid, am_wb_regdest, am_wb_writereg, am_wb_data,
        input  mem_wb_valid, mem_wb_regdest, mem_wb_writereg, mem_wb_data,
        input  mul_wb_valid, mul_wb_regdest, mul_wb_writereg, mul_wb_data,
        output wb_am_stall, wb_mem_stall, wb_mul_stall,
        output wb_reg_writeaddr, wb_reg_writedata, wb_reg_enablewrite,
        output wb_sb_clear, wb_sb_clearaddr, wb_sb_clearunit
    );

    modport master (
        output am_wb_valid, am_wb_regdest, am_wb_writereg, am_wb_data,
        output mem_wb_valid, mem_wb_regdest, mem_wb_writereg, mem_wb_data,
        output mul_wb_valid, mul_wb_regdest, mul_wb_writereg, mul_wb_data,
        input  wb_am_stall, wb_mem_stall, wb_mul_stall,
        input  wb_reg_writeaddr, wb_reg_writedata, wb_reg_enablewrite,
        input  wb_sb_clear, wb_sb_clearaddr, wb_sb_clearunit
    );
endinterface

// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - one-entry buffer per functional unit, round-robin retirement to the ARF and scoreboard
module writeback_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    writeback_arbiter_if.slave    wb
);
    localparam int NUNITS = 3;

    logic [NUNITS-1:0]     in_valid;
    logic [NUNITS-1:0]     in_wr;
    logic [ADDR_WIDTH-1:0] in_rd   [NUNITS];
    logic [DATA_WIDTH-1:0] in_data [NUNITS];

    logic [NUNITS-1:0]     occ_q;
    logic [NUNITS-1:0]     wr_q;
    logic [ADDR_WIDTH-1:0] rd_q   [NUNITS];
    logic [DATA_WIDTH-1:0] data_q [NUNITS];
    logic [1:0]            rr_q;

    logic [ADDR_WIDTH-1:0] writeaddr_q;
    logic [DATA_WIDTH-1:0] writedata_q;
    logic                  enablewrite_q;
    logic                  sb_clear_q;
    logic [ADDR_WIDTH-1:0] sb_clearaddr_q;
    logic [1:0]            sb_clearunit_q;

    logic [NUNITS-1:0]     grant;
    logic [1:0]            gnt_unit;
    logic                  found;
    logic [2:0]            sum;
    logic [1:0]            rr_d;

    assign in_valid   = {wb.mul_wb_valid, wb.mem_wb_valid, wb.am_wb_valid};
    assign in_wr      = {wb.mul_wb_writereg, wb.mem_wb_writereg, wb.am_wb_writereg};
    assign in_rd[0]   = wb.am_wb_regdest;
    assign in_rd[1]   = wb.mem_wb_regdest;
    assign in_rd[2]   = wb.mul_wb_regdest;
    assign in_data[0] = wb.am_wb_data;
    assign in_data[1] = wb.mem_wb_data;
    assign in_data[2] = wb.mul_wb_data;

    // Scan rr, rr+1, rr+2 (mod 3); the first occupied buffer wins.
    always_comb begin
        grant    = '0;
        gnt_unit = 2'b00;
        found    = 1'b0;
        sum      = 3'd0;
        for (int k = 0; k < NUNITS; k++) begin
            sum = {1'b0, rr_q} + 3'(k);
            if (sum >= 3'd3) sum = sum - 3'd3;
            if (!found && occ_q[sum[1:0]]) begin
                grant[sum[1:0]] = 1'b1;
                gnt_unit        = sum[1:0];
                found           = 1'b1;
            end
        end
    end

    assign rr_d = (gnt_unit == 2'd2) ? 2'd0 : gnt_unit + 2'd1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            occ_q          <= '0;
            wr_q           <= '0;
            rr_q           <= 2'b00;
            writeaddr_q    <= '0;
            writedata_q    <= '0;
            enablewrite_q  <= 1'b0;
            sb_clear_q     <= 1'b0;
            sb_clearaddr_q <= '0;
            sb_clearunit_q <= 2'b00;
            for (int i = 0; i < NUNITS; i++) begin
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (found) begin
                writeaddr_q    <= rd_q[gnt_unit];
                writedata_q    <= data_q[gnt_unit];
                enablewrite_q  <= wr_q[gnt_unit] && (rd_q[gnt_unit] != '0);
                sb_clear_q     <= wr_q[gnt_unit];
                sb_clearaddr_q <= rd_q[gnt_unit];
                sb_clearunit_q <= gnt_unit;
                rr_q           <= rr_d;
            end else begin
                enablewrite_q  <= 1'b0;
                sb_clear_q     <= 1'b0;
            end
            // A granted buffer may reload in the same edge it drains, so a streaming unit never bubbles.
            for (int i = 0; i < NUNITS; i++) begin
                if (in_valid[i] && (!occ_q[i] || grant[i])) begin
                    occ_q[i]  <= 1'b1;
                    wr_q[i]   <= in_wr[i];
                    rd_q[i]   <= in_rd[i];
                    data_q[i] <= in_data[i];
                end else if (grant[i]) begin
                    occ_q[i]  <= 1'b0;
                end
            end
        end
    end

    assign wb.wb_am_stall        = occ_q[0] && !grant[0];
    assign wb.wb_mem_stall       = occ_q[1] && !grant[1];
    assign wb.wb_mul_stall       = occ_q[2] && !grant[2];
    assign wb.wb_reg_writeaddr   = writeaddr_q;
    assign wb.wb_reg_writedata   = writedata_q;
    assign wb.wb_reg_enablewrite = enablewrite_q;
    assign wb.wb_sb_clear        = sb_clear_q;
    assign wb.wb_sb_clearaddr    = sb_clearaddr_q;
    assign wb.wb_sb_clearunit    = sb_clearunit_q;
endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Completion/writeback stage on the far side of the issue stage.
- Collects results from the three functional units: AluMisc (unit 2'b00), Mem (2'b01) and Mult (2'b10).
- Retires at most one result per cycle through the single ARF write port.
- On each retirement, pulses a scoreboard-clear for the destination register, releasing the pending entry that issue set.
- Each unit gets a one-entry holding buffer; a round-robin arbiter picks the buffer to retire; a busy unit is stalled.

Parameters:
DATA_WIDTH, 32, width of result data and ARF write data
ADDR_WIDTH, 5, register address width

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
am_wb_valid  in  1  AluMisc result valid this cycle
am_wb_regdest  in  ADDR_WIDTH  AluMisc destination register
am_wb_writereg  in  1  AluMisc result writes a register
am_wb_data  in  DATA_WIDTH  AluMisc result value
mem_wb_valid  in  1  Mem result valid
mem_wb_regdest  in  ADDR_WIDTH  Mem destination register
mem_wb_writereg  in  1  Mem writes a register (0 for stores)
mem_wb_data  in  DATA_WIDTH  Mem load value
mul_wb_valid  in  1  Mult result valid
mul_wb_regdest  in  ADDR_WIDTH  Mult destination register
mul_wb_writereg  in  1  Mult writes a register
mul_wb_data  in  DATA_WIDTH  Mult result value
wb_am_stall  out  1  AluMisc must hold its result
wb_mem_stall  out  1  Mem must hold its result
wb_mul_stall  out  1  Mult must hold its result
wb_reg_writeaddr  out  ADDR_WIDTH  ARF write address
wb_reg_writedata  out  DATA_WIDTH  ARF write data
wb_reg_enablewrite  out  1  ARF write enable
wb_sb_clear  out  1  scoreboard clear strobe
wb_sb_clearaddr  out  ADDR_WIDTH  register whose pending bit is cleared
wb_sb_clearunit  out  2  unit code of the retiring result

Behaviour:
- Reset (reset=0, asynchronous):
  - All buffers empty; round-robin pointer rr=2'b00.
  - All wb_reg_*, wb_sb_* outputs 0; all stalls 0.
  - A reset mid-operation discards all buffered results.
- Per-unit buffer: holds occupied flag, regdest, writereg and data.
- Arbitration (combinational, same cycle):
  - Candidates are the occupied buffers.
  - Search order starts at rr and proceeds rr, rr+1, rr+2 (mod 3); the first occupied buffer is granted.
  - At most one grant per cycle.
- Retire at the rising edge when a grant exists:
  - wb_reg_writeaddr <= regdest; wb_reg_writedata <= data.
  - wb_reg_enablewrite <= writereg && regdest!=0.
  - wb_sb_clear <= writereg; wb_sb_clearaddr <= regdest; wb_sb_clearunit <= unit code.
  - rr <= (granted unit + 1) mod 3.
  - With no grant, all enables/strobes are 0 next cycle; address/data outputs hold their last values; rr is unchanged.
- Results with writereg=0 (e.g. stores):
  - Still consume a retirement slot, with enablewrite=0 and sb_clear=0.
  - Their outputs update addr/data anyway.
- Capture: unit buffer loads the input on the edge when x_wb_valid=1 and (buffer empty or buffer granted this cycle).
  - Granted with no new valid: buffer becomes empty.
  - Granted with simultaneous new valid: buffer reloads with the new result in the same edge, so there is no bubble.
- Stall (combinational): wb_x_stall = buffer occupied && !granted this cycle.
  - While stall=1 the unit holds valid and all fields stable; the arbiter ignores the input.
  - Asserting valid while stalled is legal and is not a loss.
- Latency: result captured at edge N retires at edge N+1 at the earliest.
  - ARF/scoreboard outputs are high for exactly one cycle per retirement.
- Worst case, all three buffers occupied: each waits at most 2 retirements, so there is no starvation.
- Ordering between units is not preserved. The WAW check in issue guarantees no two in-flight results share a destination, so the arbiter performs no address comparison.
- Unit code 2'b11 is never produced.

Test Plan:
1. Single AluMisc result: am valid, rd=5, data=0x0000_002A at edge 1 -> after edge 2: enablewrite=1, writeaddr=5, writedata=0x2A, sb_clear=1, clearunit=00; after edge 3: all strobes 0.
2. Simultaneous completion: am rd=1, mem rd=2, mul rd=3 all valid after reset (rr=0) -> retirements on three consecutive cycles in order rd1(00), rd2(01), rd3(10); wb_mem_stall=1 for 1 cycle and wb_mul_stall=1 for 2 cycles; stall cycles counted from the cycle after capture.
3. Back-to-back from one unit: mul valid on 4 consecutive cycles with rd=8..11, no other traffic -> four consecutive writes rd8..rd11 with wb_mul_stall never asserted.
4. Store and x0: mem valid, writereg=0 -> slot used, enablewrite=0, sb_clear=0. am valid, writereg=1, rd=0 -> enablewrite=0, sb_clear=1, clearaddr=0.
5. Fairness: am and mul continuously valid -> grants alternate am, mul, am, mul; neither waits more than 1 cycle once buffered.
6. Reset mid-operation: fill all three buffers, pull reset low between edges -> outputs and stalls immediately 0; after release, no retirement of the old results; rr=0.
